// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver.
//   Oversampled (OS ticks per bit), 3-sample majority vote around mid-bit,
//   false-start rejection, parity none/even/odd, 1 or 2 stop bits,
//   parity/framing/break reporting.
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   rx           asynchronous serial input, idle high
//   s_tick       oversample enable, OS pulses per bit time
//   par_mode     00 none, 01 even, 10 odd, 11 none (latched at frame start)
//   stop2        0 one stop bit, 1 two stop bits (latched at frame start)
//   rx_done_tick one-clk pulse when a frame completes
//   dout         last received data word, right-aligned
//   parity_err   parity mismatch of last frame
//   frame_err    a stop bit of the last frame was 0
//   break_det    last frame was a break (all zero through first stop bit)
//   busy         receiver is not idle
module uart_rx_cfg #(
  parameter int DBIT = 8,
  parameter int OS   = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  input  logic [1:0]      par_mode,
  input  logic            stop2,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            busy
);

  localparam int SW = $clog2(OS);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_ZERO = SW'(0);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_V0   = SW'(OS/2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OS/2);
  localparam logic [SW-1:0] S_V2   = SW'(OS/2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
  localparam logic [NW-1:0] N_ZERO = NW'(0);
  localparam logic [NW-1:0] N_ONE  = NW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [DBIT-1:0] D_ZERO = {DBIT{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } state_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Even parity expects bit == XOR(data); odd expects its inverse.
  function automatic logic parity_error(input logic [DBIT-1:0] d, input logic odd, input logic pbit);
    return (^d) ^ odd ^ pbit;
  endfunction

  logic [1:0]      sync_r;
  logic            rx_s;
  state_t          state_r, state_next;
  logic [SW-1:0]   s_r, s_next;
  logic [NW-1:0]   n_r, n_next;
  logic [1:0]      vote_r, vote_next;
  logic            bit_r, bit_next;
  logic [DBIT-1:0] data_r, data_next;
  logic            par_en_r, par_en_next, par_odd_r, par_odd_next, stop2_r, stop2_next;
  logic            par_bit_r, par_bit_next, fe_r, fe_next, stop1_zero_r, stop1_zero_next;
  logic            done_r, done_next, perr_r, perr_next, ferr_r, ferr_next;
  logic            brk_r, brk_next, busy_r, busy_next;
  logic [DBIT-1:0] dout_r, dout_next;
  logic [2:0]      vote_shift_s;
  logic            maj_s, in_win_s;

  // Two-flop synchroniser on the asynchronous line; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_r <= 2'b11;
    else          sync_r <= {sync_r[0], rx};
  end
  assign rx_s = sync_r[1];

  // The two stored samples plus the live one form the 3-sample window,
  // so the majority is available on the tick that takes the last sample.
  assign vote_shift_s = {vote_r, rx_s};
  assign maj_s        = maj3(vote_shift_s);
  assign in_win_s     = (s_r == S_V0) || (s_r == S_MID) || (s_r == S_V2);

  // Next-state and datapath logic for the receive FSM.
  always_comb begin
    state_next      = state_r;
    s_next          = s_r;
    n_next          = n_r;
    vote_next       = vote_r;
    bit_next        = bit_r;
    data_next       = data_r;
    par_en_next     = par_en_r;
    par_odd_next    = par_odd_r;
    stop2_next      = stop2_r;
    par_bit_next    = par_bit_r;
    fe_next         = fe_r;
    stop1_zero_next = stop1_zero_r;
    done_next       = 1'b0;
    dout_next       = dout_r;
    perr_next       = perr_r;
    ferr_next       = ferr_r;
    brk_next        = brk_r;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next      = ST_START;
          s_next          = S_ZERO;
          n_next          = N_ZERO;
          vote_next       = 2'b00;
          par_en_next     = (par_mode == 2'b01) || (par_mode == 2'b10);
          par_odd_next    = (par_mode == 2'b10);
          stop2_next      = stop2;
          par_bit_next    = 1'b0;
          fe_next         = 1'b0;
          stop1_zero_next = 1'b0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      // A held-low line must return high before a new frame can start.
      ST_BRK_WAIT: state_next = rx_s ? ST_IDLE : ST_BRK_WAIT;
      ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
        if (s_tick) begin
          s_next    = (s_r == S_LAST) ? S_ZERO : s_r + S_ONE;
          vote_next = in_win_s ? vote_shift_s[1:0] : vote_r;
          bit_next  = (s_r == S_V2) ? maj_s : bit_r;
          case (state_r)
            ST_START: begin
              if ((s_r == S_V2) && maj_s) begin
                state_next = ST_IDLE;
                s_next     = S_ZERO;
              end else if (s_r == S_LAST) begin
                state_next = ST_DATA;
                n_next     = N_ZERO;
              end else begin
                state_next = ST_START;
              end
            end
            ST_DATA: begin
              if (s_r == S_LAST) begin
                data_next = {bit_r, data_r[DBIT-1:1]};
                if (n_r == N_LAST) begin
                  n_next     = N_ZERO;
                  state_next = par_en_r ? ST_PARITY : ST_STOP;
                end else begin
                  n_next = n_r + N_ONE;
                end
              end else begin
                data_next = data_r;
              end
            end
            ST_PARITY: begin
              if (s_r == S_LAST) begin
                par_bit_next = bit_r;
                n_next       = N_ZERO;
                state_next   = ST_STOP;
              end else begin
                par_bit_next = par_bit_r;
              end
            end
            ST_STOP: begin
              if ((s_r == S_V2) && !maj_s) begin
                fe_next         = 1'b1;
                stop1_zero_next = stop1_zero_r | (n_r == N_ZERO);
              end else begin
                fe_next = fe_r;
              end
              if (s_r == S_LAST) begin
                if (stop2_r && (n_r == N_ZERO)) begin
                  n_next = N_ONE;
                end else begin
                  done_next  = 1'b1;
                  dout_next  = data_r;
                  perr_next  = par_en_r & parity_error(data_r, par_odd_r, par_bit_r);
                  ferr_next  = fe_r;
                  brk_next   = (data_r == D_ZERO) && !(par_en_r && par_bit_r) && stop1_zero_r;
                  n_next     = N_ZERO;
                  s_next     = S_ZERO;
                  state_next = fe_r ? ST_BRK_WAIT : ST_IDLE;
                end
              end else begin
                n_next = n_r;
              end
            end
            default: state_next = ST_IDLE;
          endcase
        end else begin
          state_next = state_r;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  // State, counters, shift/vote registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      s_r          <= S_ZERO;
      n_r          <= N_ZERO;
      vote_r       <= 2'b00;
      bit_r        <= 1'b0;
      data_r       <= D_ZERO;
      par_en_r     <= 1'b0;
      par_odd_r    <= 1'b0;
      stop2_r      <= 1'b0;
      par_bit_r    <= 1'b0;
      fe_r         <= 1'b0;
      stop1_zero_r <= 1'b0;
      done_r       <= 1'b0;
      dout_r       <= D_ZERO;
      perr_r       <= 1'b0;
      ferr_r       <= 1'b0;
      brk_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next;
      s_r          <= s_next;
      n_r          <= n_next;
      vote_r       <= vote_next;
      bit_r        <= bit_next;
      data_r       <= data_next;
      par_en_r     <= par_en_next;
      par_odd_r    <= par_odd_next;
      stop2_r      <= stop2_next;
      par_bit_r    <= par_bit_next;
      fe_r         <= fe_next;
      stop1_zero_r <= stop1_zero_next;
      done_r       <= done_next;
      dout_r       <= dout_next;
      perr_r       <= perr_next;
      ferr_r       <= ferr_next;
      brk_r        <= brk_next;
      busy_r       <= busy_next;
    end
  end

  assign rx_done_tick = done_r;
  assign dout         = dout_r;
  assign parity_err   = perr_r;
  assign frame_err    = ferr_r;
  assign break_det    = brk_r;
  assign busy         = busy_r;

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver. It is the successor to the fixed 8N1 receiver.
- Adds an input synchroniser and 3-sample majority-vote bit sampling.
- Validates the start bit and rejects false starts.
- Supports runtime parity (none/even/odd) and 1 or 2 stop bits.
- Reports parity error, framing error and break.
It sits between the pad-side rx line and the bus-side UART register block, and is driven by the shared baud-rate tick generator.

Parameters:
DBIT, 8, data bits per frame (5..9), LSB first.
OS, 16, s_tick oversampling ticks per bit (even, 8..32).

Ports:
clk  in  1  system clock, all logic rising-edge.
reset_n  in  1  asynchronous active-low reset.
rx  in  1  serial line, asynchronous, idle high.
s_tick  in  1  oversample tick, one clk wide, OS ticks per bit time.
par_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
stop2  in  1  0 = one stop bit, 1 = two stop bits.
rx_done_tick  out  1  one-clk pulse at frame completion.
dout  out  DBIT  received data, right-aligned, held until next frame.
parity_err  out  1  parity mismatch of last frame, held.
frame_err  out  1  any stop bit sampled 0 in last frame, held.
break_det  out  1  last frame was a break, held.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n low, async):
  - State = IDLE; all counters and shift/vote registers cleared.
  - Synchroniser flops set to 1.
  - dout = 0; rx_done_tick, parity_err, frame_err, break_det and busy = 0.
- Synchroniser: 2-FF on rx, giving rx_s. This adds 2 clk latency; all decisions use rx_s only.
- Counters:
  - s: 0..OS-1 within a bit, advances only on s_tick, wraps to 0 at OS-1.
  - n: counts data bits and, in STOP, stop bits.
- Majority vote:
  - On s_tick with s in {OS/2-1, OS/2, OS/2+1}, rx_s is shifted into a 3-bit vote register.
  - Bit value = majority of the 3 samples, evaluated at s==OS/2+1.
  - The data bit is committed at s==OS-1.
- Config latch: par_mode and stop2 are captured on the IDLE->START transition. Changes mid-frame have no effect on the current frame.
- States:
  - IDLE: rx_s==0 -> START, s=0.
  - START: at s==OS/2+1, if majority==1 (false start) -> IDLE, no pulse, no flag change. Otherwise continue; at s==OS-1 -> DATA, s=0, n=0.
  - DATA: at s==OS-1, shift the majority value into the MSB of the DBIT-wide shift register (LSB-first arrival). When n==DBIT-1 -> PARITY if parity enabled, else STOP (n=0). Otherwise n+1.
  - PARITY: at s==OS-1, capture the parity bit. Expected value = XOR of data (even) or its inverse (odd). -> STOP, n=0.
  - STOP: at s==OS/2+1, a majority of 0 sets an internal frame-error flag. At s==OS-1:
    - if stop2 and n==0 -> n=1, stay in STOP;
    - else complete the frame.
- Frame completion (one clk):
  - rx_done_tick=1.
  - dout, parity_err (0 when parity is off), frame_err and break_det are updated simultaneously.
  - Next state: BRK_WAIT if frame error, else IDLE.
- Break definition: all data bits 0, parity bit 0 (if enabled) and first stop bit 0. A break implies break_det=1 and frame_err=1.
- BRK_WAIT: stay until rx_s==1, then IDLE. This prevents a held-low line from re-triggering frames.
- Held outputs change only at frame completion or reset.
- s_tick low: state and counters frozen; rx activity only matters in IDLE.
- Simultaneous events: a start edge in the same clk as completion is ignored; it is detected in the next IDLE cycle if the line is still low.
- Reset mid-frame: immediate abort to the reset state. No rx_done_tick is produced.

Test Plan:
- 8N1, 0xA5, s_tick every clk, OS=16 -> one rx_done_tick about 160 clk after the start edge (+2 sync); dout=0xA5; all error flags 0.
- Even parity, 0x5A sent with parity bit 1 (correct is 0) -> dout=0x5A, parity_err=1. Next frame 0x5A with parity 0 -> parity_err=0.
- Start glitch low for 4 ticks, then high -> back to IDLE, no rx_done_tick, busy deasserts by tick OS/2+2, flags unchanged.
- Line low for 12 bit times (8N1), then high -> one rx_done_tick, dout=0x00, frame_err=1, break_det=1. No second frame until the line goes high; a following 0x33 is received cleanly with flags cleared.
- 2 stop bits, odd parity, 0x0F with second stop bit 0; plus a single inverted tick at s==OS/2 in data bit 3 -> majority corrects, dout=0x0F, frame_err=1, break_det=0.
- reset_n pulsed low mid-DATA -> all outputs 0, state IDLE, no rx_done_tick. A subsequent 0xC3 frame is received correctly.
